// File: rtl/execute_stage.sv
// Integer execute stage of the RV32IM pipeline: single-cycle ALU/multiply and a
// 32-step restoring divider, all feeding a registered EX/MEM output.
module execute_stage #(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [4:0]      op_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            stall_in,
  output logic            valid_out,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result_out,
  output logic            stall_out
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(DIV_ITERS + 1);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL    = 5'd2,  OP_SLT   = 5'd3,
    OP_SLTU = 5'd4,  OP_XOR  = 5'd5,  OP_SRL    = 5'd6,  OP_SRA   = 5'd7,
    OP_OR   = 5'd8,  OP_AND  = 5'd9,  OP_MUL    = 5'd10, OP_MULH  = 5'd11,
    OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU  = 5'd15,
    OP_REM  = 5'd16, OP_REMU = 5'd17
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

  div_state_e      r_state;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_div_result;

  logic            w_div_req;
  logic [SHW-1:0]  w_shamt;
  logic            w_mul_a_sgn;
  logic            w_mul_b_sgn;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_alu_result;

  assign w_div_req = valid_in & (op_in >= OP_DIV) & (op_in <= OP_REMU);
  assign stall_out = stall_in | (w_div_req & (r_state != S_DONE));

  // One shared multiplier: sign-extend each operand per op, keep the low 2*XLEN bits.
  assign w_shamt     = b_in[SHW-1:0];
  assign w_mul_a_sgn = ((op_in == OP_MULH) | (op_in == OP_MULHSU)) & a_in[XLEN-1];
  assign w_mul_b_sgn = (op_in == OP_MULH) & b_in[XLEN-1];
  assign w_prod      = {{XLEN{w_mul_a_sgn}}, a_in} * {{XLEN{w_mul_b_sgn}}, b_in};

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_alu_result = '0;
    case (op_in)
      OP_ADD:    w_alu_result = a_in + b_in;
      OP_SUB:    w_alu_result = a_in - b_in;
      OP_SLL:    w_alu_result = a_in << w_shamt;
      OP_SLT:    w_alu_result = {{(XLEN-1){1'b0}}, $signed(a_in) < $signed(b_in)};
      OP_SLTU:   w_alu_result = {{(XLEN-1){1'b0}}, a_in < b_in};
      OP_XOR:    w_alu_result = a_in ^ b_in;
      OP_SRL:    w_alu_result = a_in >> w_shamt;
      OP_SRA:    w_alu_result = $signed(a_in) >>> w_shamt;
      OP_OR:     w_alu_result = a_in | b_in;
      OP_AND:    w_alu_result = a_in & b_in;
      OP_MUL:    w_alu_result = w_prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  w_alu_result = w_prod[2*XLEN-1:XLEN];
      default:   w_alu_result = '0;
    endcase
  end

  // Divide decode: REM/REMU have op bit 4 set, the unsigned variants have bit 0 set.
  logic            w_is_rem;
  logic            w_is_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN-1:0] w_special_result;

  assign w_is_rem    = op_in[4];
  assign w_is_signed = ~op_in[0];
  assign w_a_neg     = w_is_signed & a_in[XLEN-1];
  assign w_b_neg     = w_is_signed & b_in[XLEN-1];
  assign w_abs_a     = w_a_neg ? -a_in : a_in;
  assign w_abs_b     = w_b_neg ? -b_in : b_in;
  assign w_div_zero  = (b_in == '0);
  assign w_overflow  = w_is_signed & (a_in == {1'b1, {(XLEN-1){1'b0}}}) & (&b_in);

  always_comb begin
    w_special_result = '0;
    if (w_div_zero) w_special_result = w_is_rem ? a_in : '1;
    else            w_special_result = w_is_rem ? '0   : a_in;
  end

  // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  logic [XLEN:0]   w_rem_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;
  logic [XLEN-1:0] w_quo_next;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_div_final;

  assign w_rem_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_dvs};
  assign w_fits      = ~w_diff[XLEN];
  assign w_quo_next  = {r_quo[XLEN-2:0], w_fits};
  assign w_rem_next  = w_fits ? w_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];
  assign w_div_final = r_is_rem ? (r_neg_r ? -w_rem_next : w_rem_next)
                                : (r_neg_q ? -w_quo_next : w_quo_next);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_dvs        <= '0;
      r_is_rem     <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_div_result <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (w_div_req) begin
            if (w_div_zero | w_overflow) begin
              r_div_result <= w_special_result;
              r_state      <= S_DONE;
            end else begin
              r_quo    <= w_abs_a;
              r_rem    <= '0;
              r_dvs    <= w_abs_b;
              r_is_rem <= w_is_rem;
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_count  <= CW'(DIV_ITERS);
              r_state  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_quo   <= w_quo_next;
          r_rem   <= w_rem_next;
          r_count <= r_count - 1'b1;
          if (r_count == CW'(1)) begin
            r_div_result <= w_div_final;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (!stall_in) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out  <= 1'b0;
      rd_out     <= '0;
      result_out <= '0;
    end else if (!stall_in) begin
      if (w_div_req && r_state != S_DONE) begin
        valid_out <= 1'b0;
      end else begin
        valid_out  <= valid_in;
        rd_out     <= rd_in;
        result_out <= (r_state == S_DONE) ? r_div_result : w_alu_result;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed corner cases plus randomized
// instruction streams checked against an arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [4:0]  op_in = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        stall_in = 1'b0;
  logic        valid_out;
  logic [4:0]  rd_out;
  logic [31:0] result_out;
  logic        stall_out;

  execute_stage #(.XLEN(32), .DIV_ITERS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .op_in      (op_in),
    .rd_in      (rd_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .stall_in   (stall_in),
    .valid_out  (valid_out),
    .rd_out     (rd_out),
    .result_out (result_out),
    .stall_out  (stall_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected EX/MEM contents and cycles the held divide still needs before it can retire.
  logic        m_valid = 1'b0;
  logic [4:0]  m_rd    = '0;
  logic [31:0] m_res   = '0;
  int          m_remaining = 0;
  int          stall_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_div(input logic [4:0] op);
    return (op >= 5'd14) && (op <= 5'd17);
  endfunction

  function automatic bit is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) ||
           (((op == 5'd14) || (op == 5'd16)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, ua;
    logic [63:0] p;
    int          ia, ib;
    sa = int'(a);
    sb = int'(b);
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = int'(a);
    ib = int'(b);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return (ia < ib) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'($signed(a) >>> b[4:0]);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: begin p = 64'(ua * ub); return p[31:0]; end
      5'd11: begin p = 64'(sa * sb); return p[63:32]; end
      5'd12: begin p = 64'(sa * ub); return p[63:32]; end
      5'd13: begin p = 64'(ua * ub); return p[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (is_special(op, a, b)) return a;
        return 32'(ia / ib);
      end
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (is_special(op, a, b)) return 32'h0;
        return 32'(ia % ib);
      end
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Entered and left at posedge+1: checks stall_out, advances the model over one edge, checks outputs.
  task automatic do_cycle(output bit accepted);
    bit held_div;
    bit exp_stall;
    #3;
    held_div  = valid_in && is_div(op_in) && (m_remaining > 0);
    exp_stall = stall_in || held_div;
    check("stall_out", 32'(stall_out), 32'(exp_stall));
    if (stall_out) stall_cnt++;
    accepted = !exp_stall;
    if (!stall_in) begin
      if (held_div) begin
        m_valid = 1'b0;
      end else begin
        m_valid = valid_in;
        if (valid_in) begin
          m_rd  = rd_in;
          m_res = ref_result(op_in, a_in, b_in);
        end
      end
    end
    if (held_div) m_remaining--;
    @(posedge clk);
    #1;
    check("valid_out", 32'(valid_out), 32'(m_valid));
    if (m_valid) begin
      check("rd_out", 32'(rd_out), 32'(m_rd));
      check("result_out", result_out, m_res);
    end
  endtask

  task automatic run_instr(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int stall_from, input int stall_len,
                           input bit rnd_stall);
    bit acc;
    valid_in    = 1'b1;
    op_in       = op;
    a_in        = a;
    b_in        = b;
    rd_in       = rd;
    stall_cnt   = 0;
    m_remaining = is_div(op) ? (is_special(op, a, b) ? 1 : 33) : 0;
    for (int k = 0; k < 200; k++) begin
      stall_in = ((k >= stall_from) && (k < stall_from + stall_len)) ||
                 (rnd_stall && ($urandom_range(0, 7) == 0));
      do_cycle(acc);
      if (acc) begin
        valid_in = 1'b0;
        stall_in = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
    valid_in    = 1'b0;
    stall_in    = 1'b0;
    m_remaining = 0;
  endtask

  task automatic bubble();
    bit acc;
    valid_in = 1'b0;
    op_in    = 5'($urandom_range(0, 31));
    a_in     = $urandom;
    b_in     = $urandom;
    rd_in    = 5'($urandom_range(0, 31));
    stall_in = 1'b0;
    do_cycle(acc);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear immediately.
  task automatic apply_reset();
    valid_in = 1'b0;
    stall_in = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_result", result_out, 32'd0);
    m_valid     = 1'b0;
    m_rd        = '0;
    m_res       = '0;
    m_remaining = 0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(valid_out), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit acc;
    logic [4:0] rop;

    @(posedge clk);
    #1;
    check("init_valid", 32'(valid_out), 32'd0);
    check("init_rd", 32'(rd_out), 32'd0);
    check("init_result", result_out, 32'd0);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-divide, then a plain ADD must retire in one cycle.
    valid_in = 1'b1; op_in = 5'd14; a_in = 32'd1000; b_in = 32'd3; rd_in = 5'd9;
    m_remaining = 33;
    for (int k = 0; k < 5; k++) do_cycle(acc);
    apply_reset();
    for (int k = 0; k < 3; k++) bubble();
    run_instr(5'd0, 32'd5, 32'd7, 5'd3, -1, 0, 1'b0);
    check("add_valid", 32'(valid_out), 32'd1);
    check("add_rd", 32'(rd_out), 32'd3);
    check("add_result", result_out, 32'd12);

    // ALU / multiply corners.
    run_instr(5'd7, 32'h8000_0000, 32'd4, 5'd1, -1, 0, 1'b0);
    check("sra", result_out, 32'hF800_0000);
    run_instr(5'd4, 32'd1, 32'hFFFF_FFFF, 5'd2, -1, 0, 1'b0);
    check("sltu", result_out, 32'd1);
    run_instr(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, -1, 0, 1'b0);
    check("mulh", result_out, 32'd0);
    run_instr(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, -1, 0, 1'b0);
    check("mulhu", result_out, 32'hFFFF_FFFE);

    // Iterative signed divide/remainder: 33 stall cycles each.
    run_instr(5'd14, 32'hFFFF_FFEC, 32'd3, 5'd6, -1, 0, 1'b0);
    check("div_stall_cycles", 32'(stall_cnt), 32'd33);
    check("div_neg", result_out, 32'hFFFF_FFFA);
    run_instr(5'd16, 32'hFFFF_FFEC, 32'd3, 5'd7, -1, 0, 1'b0);
    check("rem_stall_cycles", 32'(stall_cnt), 32'd33);
    check("rem_neg", result_out, 32'hFFFF_FFFE);

    // Fast-path special cases: one stall cycle each.
    run_instr(5'd15, 32'd7, 32'd0, 5'd8, -1, 0, 1'b0);
    check("divu_zero_stall", 32'(stall_cnt), 32'd1);
    check("divu_zero", result_out, 32'hFFFF_FFFF);
    run_instr(5'd16, 32'd7, 32'd0, 5'd8, -1, 0, 1'b0);
    check("rem_zero_stall", 32'(stall_cnt), 32'd1);
    check("rem_zero", result_out, 32'd7);
    run_instr(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, -1, 0, 1'b0);
    check("div_ovf_stall", 32'(stall_cnt), 32'd1);
    check("div_ovf", result_out, 32'h8000_0000);

    // Memory-stage stall arriving while iterating, and again while the result waits.
    run_instr(5'd14, 32'd1000, 32'd7, 5'd10, 10, 5, 1'b0);
    check("busy_stall_cycles", 32'(stall_cnt), 32'd33);
    check("busy_stall_quot", result_out, 32'd142);
    run_instr(5'd14, 32'd1000, 32'd7, 5'd11, 33, 5, 1'b0);
    check("done_stall_cycles", 32'(stall_cnt), 32'd38);
    check("done_stall_quot", result_out, 32'd142);

    // Back-to-back divide then ADD.
    run_instr(5'd15, 32'd100, 32'd7, 5'd12, -1, 0, 1'b0);
    check("b2b_divu", result_out, 32'd14);
    run_instr(5'd0, 32'd1, 32'd2, 5'd13, -1, 0, 1'b0);
    check("b2b_add", result_out, 32'd3);
    bubble();

    // Reset while the divider is iterating: nothing may retire afterwards.
    valid_in = 1'b1; op_in = 5'd17; a_in = 32'd12345; b_in = 32'd17; rd_in = 5'd14;
    m_remaining = 33;
    for (int k = 0; k < 12; k++) do_cycle(acc);
    apply_reset();
    for (int k = 0; k < 3; k++) bubble();

    // Randomized instruction stream with bubbles and memory-stage stalls.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) bubble();
      rop = ($urandom_range(0, 9) < 3) ? 5'(14 + $urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      run_instr(rop, rand_operand(), rand_operand(), 5'($urandom_range(0, 31)), -1, 0, 1'b1);
    end
    bubble();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Integer execute stage of the 5-stage RV32IM pipeline.
- Sits between decode and the memory stage.
- Computes RV32I ALU and RV32M multiply/divide results into a registered EX/MEM output.
- MUL ops are single-cycle. DIV/REM ops use a 32-iteration restoring divider FSM that stalls upstream until the result is ready.
- Honours the stall coming back from the memory stage.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- DIV_ITERS, 32, divider iteration count (must equal XLEN)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- valid_in  input  1  decode presents a valid instruction
- op_in  input  5  operation code (encoding below)
- rd_in  input  5  destination register
- a_in  input  32  operand A (rs1 after bypass)
- b_in  input  32  operand B (rs2 or immediate)
- stall_in  input  1  memory stage cannot accept (stall_mem_out)
- valid_out  output  1  EX/MEM register holds a valid instruction
- rd_out  output  5  registered destination register
- result_out  output  32  registered result
- stall_out  output  1  decode must hold its current inputs

Behaviour:
- op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU
  - 18-31 reserved: result 0, valid passes through.
- Shifts use b_in[4:0] only. SLT/SLTU return 0 or 1.
- MUL returns low 32 bits of the product. MULH/MULHSU/MULHU return high 32 bits of the 64-bit product, with signedness per RV32M. Combinational, 1 cycle.
- Reset (rst=0, async):
  - valid_out=0, rd_out=0, result_out=0, FSM=IDLE, iteration counter=0.
  - Reset mid-divide aborts the divide with no output.
- div_req = valid_in & op_in in 14..17.
- Divider FSM:
  - IDLE:
    - If div_req with a special case → DONE.
    - If div_req otherwise → BUSY. Latch |a|, |b|, signs and op; counter=DIV_ITERS.
  - BUSY: one restoring shift-subtract step per cycle, counter decrements. When counter reaches 1 and the step completes → DONE.
  - DONE: result held. Leaves to IDLE on the first edge with stall_in=0 (result captured on that edge).
- Special cases (fast path, no iteration):
  - Divisor 0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = dividend.
  - Signed overflow (0x80000000 / -1): DIV = 0x80000000, REM = 0.
- Signed results:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- stall_out = stall_in | (div_req & state != DONE). Combinational.
- Decode holds op/a/b/rd stable while stall_out=1. The divider relies on this only for the op/rd of the held instruction; operands are latched at IDLE→BUSY.
- EX/MEM register on each rising edge:
  - If stall_in=1: hold all outputs.
  - Else if div_req & state != DONE: insert bubble (valid_out=0; rd_out and result_out hold).
  - Else: valid_out = valid_in; rd_out = rd_in; result_out = computed result, or the divider result when state=DONE.
- Latency:
  - ALU/MUL: result visible 1 cycle after presentation.
  - Normal divide presented in cycle c (no stall_in): stall_out high for cycles c..c+32; result visible after the edge ending cycle c+33 (34 cycles).
  - Special-case divide: stall_out high in cycle c only; result after the edge ending c+1.
- stall_in asserted while in BUSY: iteration continues. In DONE the FSM waits; stall_out stays high via stall_in.
- Back-to-back divides: FSM returns to IDLE, so the next div_req starts a fresh divide.
- valid_in=0: no FSM activity; a bubble propagates.
- rd=0: not special-cased; writeback discards it.

Test Plan:
- Reset: rst low mid-operation → all outputs 0, FSM IDLE; after release, ADD 5+7 (rd=3) → next cycle valid_out=1, rd_out=3, result_out=12.
- ALU/MUL sweep:
  - SRA 0x80000000 by 4 → 0xF8000000
  - SLTU 1 vs 0xFFFFFFFF → 1
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0
  - MULHU same operands → 0xFFFFFFFE
- DIV −20/3 → stall_out high exactly 33 cycles, valid_out low during those cycles, then result 0xFFFFFFFA. REM with the same operands → 0xFFFFFFFE.
- Special cases, each with stall_out high 1 cycle:
  - DIVU 7/0 → 0xFFFFFFFF
  - REM 7/0 → 7
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
- stall_in held high 5 cycles, arriving both while BUSY and while DONE → outputs frozen, no result lost or duplicated, quotient correct on release.
- Back-to-back DIVU 100/7 then ADD → 14 appears once, then the ADD result on the following cycle. Async reset asserted mid-BUSY → no valid_out, FSM IDLE.
